// File: rtl/aq_djpeg_idct_xbuf_pkg.sv
// Shared geometry and helpers for the IDCT transpose buffer: block shape, read-address
// field positions and bank-pointer sizing.
package aq_djpeg_idct_xbuf_pkg;

    localparam int unsigned BlockRows  = 8;
    localparam int unsigned RowBeats   = 4;
    localparam int unsigned ReadAddrs  = 32;
    localparam int unsigned BlockWords = 64;

    // Read address a: column j = a[4:2], row pair k = a[1:0]
    localparam int unsigned AddrColMsb = 4;
    localparam int unsigned AddrColLsb = 2;
    localparam int unsigned AddrRowMsb = 1;

    localparam logic [2:0] LastPage  = 3'(BlockRows - 1);
    localparam logic [1:0] LastCount = 2'(RowBeats - 1);
    localparam logic [4:0] LastAddr  = 5'(ReadAddrs - 1);

    function automatic int unsigned ptrWidth(input int unsigned banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/aq_djpeg_idct_xbuf_if.sv
// Row-pass write beats and column-pass read port of the transpose buffer.
// slave is the buffer side; master is the row/column-pass side.
interface aq_djpeg_idct_xbuf_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16
) ();

    logic             DataInEnable;
    logic [2:0]       DataInPage;
    logic [1:0]       DataInCount;
    logic [IN_W-1:0]  DataInA;
    logic [IN_W-1:0]  DataInB;
    logic             DataInIdle;

    logic             DataOutEnable;
    logic             DataOutRead;
    logic [4:0]       DataOutAddress;
    logic [OUT_W-1:0] DataOutA;
    logic [OUT_W-1:0] DataOutB;

    modport master (
        output DataInEnable, DataInPage, DataInCount, DataInA, DataInB,
        output DataOutRead, DataOutAddress,
        input  DataInIdle, DataOutEnable, DataOutA, DataOutB
    );

    modport slave (
        input  DataInEnable, DataInPage, DataInCount, DataInA, DataInB,
        input  DataOutRead, DataOutAddress,
        output DataInIdle, DataOutEnable, DataOutA, DataOutB
    );

endinterface

// File: rtl/aq_djpeg_idct_xbuf_scale.sv
// Converts one signed row-pass result into a column-pass operand: optional round-half-up,
// slice at SHIFT, then either wrap or clamp to the signed OUT_W range.
module aq_djpeg_idct_xbuf_scale #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 11,
    parameter int unsigned ROUND = 0,
    parameter int unsigned SAT   = 0
) (
    input  logic [IN_W-1:0]  dataIn,
    output logic [OUT_W-1:0] dataOut,
    output logic             clamp
);

    localparam int unsigned RoundPos = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [IN_W:0] RoundAdd =
        (ROUND != 0 && SHIFT > 0) ? ((IN_W + 1)'(1) << RoundPos) : '0;
    localparam logic signed [IN_W:0] MaxVal = (IN_W + 1)'((64'd1 << (OUT_W - 1)) - 64'd1);
    localparam logic signed [IN_W:0] MinVal = ~MaxVal;

    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;

    // One guard bit so the rounding add cannot overflow.
    always_comb begin
        sum     = $signed({dataIn[IN_W-1], dataIn}) + RoundAdd;
        shifted = sum >>> SHIFT;
        dataOut = shifted[OUT_W-1:0];
        clamp   = 1'b0;
        if (SAT != 0) begin
            if (shifted > MaxVal) begin
                dataOut = MaxVal[OUT_W-1:0];
                clamp   = 1'b1;
            end else if (shifted < MinVal) begin
                dataOut = MinVal[OUT_W-1:0];
                clamp   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aq_djpeg_idct_xbuf.sv
// Multi-bank 8x8 transpose buffer between the IDCT row and column passes. Banks fill and
// drain in ring order; each holds one scaled block and is served transposed.
module aq_djpeg_idct_xbuf
    import aq_djpeg_idct_xbuf_pkg::*;
#(
    parameter int unsigned BANKS = 2,
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 11,
    parameter int unsigned ROUND = 0,
    parameter int unsigned SAT   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  DataInit,
    aq_djpeg_idct_xbuf_if.slave   bus,
    output logic                  Overrun,
    output logic                  Overflow
);

    localparam int unsigned PtrW = ptrWidth(BANKS);
    localparam int unsigned MemW = PtrW + 6;

    typedef logic [PtrW-1:0] ptrT;

    logic [OUT_W-1:0] mem [BANKS*BlockWords];

    logic [BANKS-1:0] bankFull_q, bankFull_d;
    ptrT              wrPtr_q, wrPtr_d;
    ptrT              rdPtr_q, rdPtr_d;
    logic             overrun_q, overrun_d;
    logic             overflow_q, overflow_d;
    logic [OUT_W-1:0] outA_q, outB_q;

    logic [OUT_W-1:0] scaledA, scaledB;
    logic             clampA, clampB;
    logic             wrFull, rdFull, lastBeat;
    logic             wrAccept, rdAccept, rdRelease;
    logic [2:0]       rdCol;
    logic [1:0]       rdRow;
    logic [MemW-1:0]  wrAddrA, wrAddrB, rdAddrA, rdAddrB;

    function automatic ptrT nextPtr(input ptrT p);
        return (p == ptrT'(BANKS - 1)) ? '0 : p + ptrT'(1);
    endfunction

    aq_djpeg_idct_xbuf_scale #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT),
        .ROUND(ROUND),
        .SAT  (SAT)
    ) u_scaleA (
        .dataIn (bus.DataInA),
        .dataOut(scaledA),
        .clamp  (clampA)
    );

    aq_djpeg_idct_xbuf_scale #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .SHIFT(SHIFT),
        .ROUND(ROUND),
        .SAT  (SAT)
    ) u_scaleB (
        .dataIn (bus.DataInB),
        .dataOut(scaledB),
        .clamp  (clampB)
    );

    // Ring order means the write bank is full only when every bank is full.
    assign wrFull    = bankFull_q[wrPtr_q];
    assign rdFull    = bankFull_q[rdPtr_q];
    assign lastBeat  = (bus.DataInPage == LastPage) && (bus.DataInCount == LastCount);
    assign wrAccept  = !DataInit && bus.DataInEnable && !wrFull;
    assign rdAccept  = !DataInit && bus.DataOutRead && rdFull;
    assign rdRelease = rdAccept && (bus.DataOutAddress == LastAddr);

    assign rdCol = bus.DataOutAddress[AddrColMsb:AddrColLsb];
    assign rdRow = bus.DataOutAddress[AddrRowMsb:0];

    // Word address is {bank, row, column}; lane B covers columns 4..7 on write, rows 4..7 on read.
    assign wrAddrA = {wrPtr_q, bus.DataInPage, 1'b0, bus.DataInCount};
    assign wrAddrB = {wrPtr_q, bus.DataInPage, 1'b1, bus.DataInCount};
    assign rdAddrA = {rdPtr_q, 1'b0, rdRow, rdCol};
    assign rdAddrB = {rdPtr_q, 1'b1, rdRow, rdCol};

    always_comb begin
        bankFull_d = bankFull_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        overrun_d  = overrun_q;
        overflow_d = overflow_q;
        if (DataInit) begin
            bankFull_d = '0;
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            overrun_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (bus.DataInEnable && wrFull) begin
                overrun_d = 1'b1;
            end
            if (wrAccept && (clampA || clampB)) begin
                overflow_d = 1'b1;
            end
            if (wrAccept && lastBeat) begin
                bankFull_d[wrPtr_q] = 1'b1;
                wrPtr_d             = nextPtr(wrPtr_q);
            end
            if (rdRelease) begin
                bankFull_d[rdPtr_q] = 1'b0;
                rdPtr_d             = nextPtr(rdPtr_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bankFull_q <= '0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overrun_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            bankFull_q <= bankFull_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            overrun_q  <= overrun_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outA_q <= '0;
            outB_q <= '0;
        end else if (DataInit) begin
            outA_q <= '0;
            outB_q <= '0;
        end else if (rdAccept) begin
            outA_q <= mem[rdAddrA];
            outB_q <= mem[rdAddrB];
        end
    end

    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrAddrA] <= scaledA;
            mem[wrAddrB] <= scaledB;
        end
    end

    assign bus.DataInIdle    = ~&bankFull_q;
    assign bus.DataOutEnable = rdFull;
    assign bus.DataOutA      = outA_q;
    assign bus.DataOutB      = outB_q;
    assign Overrun           = overrun_q;
    assign Overflow          = overflow_q;

endmodule

// File: tb/tb_aq_djpeg_idct_xbuf.sv
// Drives three buffer configurations from one stimulus stream and compares each against a
// block-FIFO reference model.
module tb_aq_djpeg_idct_xbuf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init, en, rd;
    logic [2:0]  page;
    logic [1:0]  cnt;
    logic [31:0] dA, dB;
    logic [4:0]  addr;
    logic [2:0]  ovr, ovf, obsIdle, obsEn;
    logic [15:0] obsA [3];
    logic [15:0] obsB [3];

    always #5 clk = ~clk;

    aq_djpeg_idct_xbuf_if #(.IN_W(32), .OUT_W(16)) i0 ();
    aq_djpeg_idct_xbuf_if #(.IN_W(32), .OUT_W(16)) i1 ();
    aq_djpeg_idct_xbuf_if #(.IN_W(32), .OUT_W(12)) i2 ();

    assign i0.DataInEnable = en;   assign i1.DataInEnable = en;   assign i2.DataInEnable = en;
    assign i0.DataInPage = page;   assign i1.DataInPage = page;   assign i2.DataInPage = page;
    assign i0.DataInCount = cnt;   assign i1.DataInCount = cnt;   assign i2.DataInCount = cnt;
    assign i0.DataInA = dA;        assign i1.DataInA = dA;        assign i2.DataInA = dA;
    assign i0.DataInB = dB;        assign i1.DataInB = dB;        assign i2.DataInB = dB;
    assign i0.DataOutRead = rd;    assign i1.DataOutRead = rd;    assign i2.DataOutRead = rd;
    assign i0.DataOutAddress = addr;
    assign i1.DataOutAddress = addr;
    assign i2.DataOutAddress = addr;

    assign obsIdle = {i2.DataInIdle, i1.DataInIdle, i0.DataInIdle};
    assign obsEn   = {i2.DataOutEnable, i1.DataOutEnable, i0.DataOutEnable};
    assign obsA[0] = i0.DataOutA;
    assign obsA[1] = i1.DataOutA;
    assign obsA[2] = {4'b0, i2.DataOutA};
    assign obsB[0] = i0.DataOutB;
    assign obsB[1] = i1.DataOutB;
    assign obsB[2] = {4'b0, i2.DataOutB};

    aq_djpeg_idct_xbuf #(.BANKS(2), .IN_W(32), .OUT_W(16), .SHIFT(11), .ROUND(0), .SAT(0)) dut0 (
        .clk(clk), .rst(rst), .DataInit(init), .bus(i0), .Overrun(ovr[0]), .Overflow(ovf[0])
    );
    aq_djpeg_idct_xbuf #(.BANKS(2), .IN_W(32), .OUT_W(16), .SHIFT(11), .ROUND(1), .SAT(1)) dut1 (
        .clk(clk), .rst(rst), .DataInit(init), .bus(i1), .Overrun(ovr[1]), .Overflow(ovf[1])
    );
    aq_djpeg_idct_xbuf #(.BANKS(4), .IN_W(32), .OUT_W(12), .SHIFT(14), .ROUND(0), .SAT(1)) dut2 (
        .clk(clk), .rst(rst), .DataInit(init), .bus(i2), .Overrun(ovr[2]), .Overflow(ovf[2])
    );

    int cfgBanks [3] = '{2, 2, 4};
    int cfgShift [3] = '{11, 11, 14};
    int cfgOutW  [3] = '{16, 16, 12};
    int cfgRound [3] = '{0, 1, 0};
    int cfgSat   [3] = '{0, 1, 1};

    // Reference: a FIFO of complete blocks per config, plus the block being assembled.
    logic [15:0] blkData  [3][4][64];
    bit          blkMask  [3][4][64];
    int          blkCount [3];
    logic [15:0] partData [3][64];
    bit          partMask [3][64];
    logic [15:0] expA [3];
    logic [15:0] expB [3];
    bit          knownA [3];
    bit          knownB [3];
    bit          expOvr [3];
    bit          expOvf [3];

    int vecs = 0;
    int errs = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] scaleRef(input logic [31:0] x, input int d, output bit clamp);
        longint v, h, mx, mn;
        v = longint'($signed(x));
        if (cfgRound[d] != 0) v = v + (longint'(1) << (cfgShift[d] - 1));
        h  = v >>> cfgShift[d];
        mx = (longint'(1) << (cfgOutW[d] - 1)) - 1;
        mn = -mx - 1;
        clamp = 1'b0;
        if (cfgSat[d] != 0 && h > mx) begin
            h = mx;
            clamp = 1'b1;
        end else if (cfgSat[d] != 0 && h < mn) begin
            h = mn;
            clamp = 1'b1;
        end
        return 16'(h & ((longint'(1) << cfgOutW[d]) - 1));
    endfunction

    task automatic modelReset();
        for (int d = 0; d < 3; d++) begin
            blkCount[d] = 0;
            for (int w = 0; w < 64; w++) partMask[d][w] = 1'b0;
            expA[d] = '0;  expB[d] = '0;
            knownA[d] = 1'b1;  knownB[d] = 1'b1;
            expOvr[d] = 1'b0;  expOvf[d] = 1'b0;
        end
    endtask

    task automatic modelCycle(input int d);
        bit rdOk, wrOk, clA, clB;
        int k, j;
        rdOk = rd && (blkCount[d] > 0);
        wrOk = en && (blkCount[d] < cfgBanks[d]);
        if (en && !wrOk) expOvr[d] = 1'b1;
        if (rdOk) begin
            k = int'(addr[1:0]);
            j = int'(addr[4:2]);
            expA[d] = blkData[d][0][k*8 + j];
            knownA[d] = blkMask[d][0][k*8 + j];
            expB[d] = blkData[d][0][(k+4)*8 + j];
            knownB[d] = blkMask[d][0][(k+4)*8 + j];
            if (addr == 5'd31) begin
                for (int s = 0; s < 3; s++)
                    for (int w = 0; w < 64; w++) begin
                        blkData[d][s][w] = blkData[d][s+1][w];
                        blkMask[d][s][w] = blkMask[d][s+1][w];
                    end
                blkCount[d]--;
            end
        end
        if (wrOk) begin
            partData[d][page*8 + cnt]     = scaleRef(dA, d, clA);
            partData[d][page*8 + cnt + 4] = scaleRef(dB, d, clB);
            partMask[d][page*8 + cnt]     = 1'b1;
            partMask[d][page*8 + cnt + 4] = 1'b1;
            if (clA || clB) expOvf[d] = 1'b1;
            if (page == 3'd7 && cnt == 2'd3) begin
                for (int w = 0; w < 64; w++) begin
                    blkData[d][blkCount[d]][w] = partData[d][w];
                    blkMask[d][blkCount[d]][w] = partMask[d][w];
                    partMask[d][w] = 1'b0;
                end
                blkCount[d]++;
            end
        end
    endtask

    // Check current outputs against the model, then advance model and DUT one clock.
    task automatic stepCycle();
        #1;
        if (!rst) modelReset();
        for (int d = 0; d < 3; d++) begin
            checkEq($sformatf("d%0d idle", d), 32'(obsIdle[d]), 32'(blkCount[d] < cfgBanks[d]));
            checkEq($sformatf("d%0d outEnable", d), 32'(obsEn[d]), 32'(blkCount[d] > 0));
            if (knownA[d]) checkEq($sformatf("d%0d DataOutA", d), 32'(obsA[d]), 32'(expA[d]));
            if (knownB[d]) checkEq($sformatf("d%0d DataOutB", d), 32'(obsB[d]), 32'(expB[d]));
            checkEq($sformatf("d%0d overrun", d), 32'(ovr[d]), 32'(expOvr[d]));
            checkEq($sformatf("d%0d overflow", d), 32'(ovf[d]), 32'(expOvf[d]));
        end
        if (rst && init) modelReset();
        else if (rst) for (int d = 0; d < 3; d++) modelCycle(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cyc(input bit e, input int p, input int c, input logic [31:0] a,
                       input logic [31:0] b, input bit r, input int ad);
        init = 1'b0;  en = e;  page = 3'(p);  cnt = 2'(c);
        dA = a;  dB = b;  rd = r;  addr = 5'(ad);
        stepCycle();
    endtask

    task automatic pulseInit();
        init = 1'b1;  en = 1'b1;  rd = 1'b1;  addr = 5'd31;
        stepCycle();
        init = 1'b0;  en = 1'b0;  rd = 1'b0;
    endtask

    task automatic writeBlockPat(input int base);
        for (int i = 0; i < 32; i++) begin
            int p, c;
            p = i / 4;
            c = i % 4;
            cyc(1'b1, p, c, 32'((p*8 + c + base) << 11), 32'((p*8 + c + 4 + base) << 11), 1'b0, 0);
        end
    endtask

    task automatic readBlock();
        for (int a = 0; a < 32; a++) cyc(1'b0, 0, 0, '0, '0, 1'b1, a);
    endtask

    initial begin
        int beat, ra;
        logic [31:0] x, y;
        init = 1'b0;  en = 1'b0;  rd = 1'b0;  page = '0;  cnt = '0;
        dA = '0;  dB = '0;  addr = '0;
        modelReset();
        @(negedge clk);
        stepCycle();
        stepCycle();
        rst = 1'b1;
        checkEq("reset idle", 32'(obsIdle), 32'h7);
        checkEq("reset outEnable", 32'(obsEn), 32'h0);
        stepCycle();

        // In-order block; transposed read-back
        writeBlockPat(0);
        checkEq("t1 outEnable", 32'(obsEn[0]), 32'h1);
        readBlock();
        checkEq("t1 a31 A", 32'(obsA[0]), 32'd31);
        checkEq("t1 a31 B", 32'(obsB[0]), 32'd63);
        cyc(1'b0, 0, 0, '0, '0, 1'b0, 0);

        // Rounding, saturation and wrap on directed values
        cyc(1'b1, 0, 0, 32'h0400_0000, 32'h0000_0400, 1'b0, 0);
        cyc(1'b1, 0, 1, 32'h0000_03FF, 32'hFFFF_F800, 1'b0, 0);
        for (int i = 2; i < 32; i++) cyc(1'b1, i / 4, i % 4, '0, '0, 1'b0, 0);
        checkEq("t3 overflow sat", 32'(ovf[1]), 32'h1);
        checkEq("t3 overflow wrap", 32'(ovf[0]), 32'h0);
        for (int a = 0; a < 32; a++) begin
            cyc(1'b0, 0, 0, '0, '0, 1'b1, a);
            if (a == 0) begin
                checkEq("t3 sat clamp", 32'(obsA[1]), 32'h7FFF);
                checkEq("t3 wrap", 32'(obsA[0]), 32'h8000);
            end
            if (a == 4) checkEq("t3 round down", 32'(obsA[1]), 32'h0);
            if (a == 16) checkEq("t3 round up", 32'(obsA[1]), 32'h1);
        end

        // Fill every bank, then overrun, then drain in order
        pulseInit();
        for (int b = 0; b < 5; b++) begin
            writeBlockPat(b + 1);
            if (b == 1) begin
                checkEq("t2 idle full", 32'(obsIdle[0]), 32'h0);
                checkEq("t2 no overrun yet", 32'(ovr[0]), 32'h0);
            end
            if (b == 3) checkEq("t6 no overrun at 4", 32'(ovr[2]), 32'h0);
        end
        checkEq("t2 overrun", 32'(ovr[0]), 32'h1);
        checkEq("t6 overrun", 32'(ovr[2]), 32'h1);
        for (int b = 0; b < 4; b++) readBlock();
        cyc(1'b0, 0, 0, '0, '0, 1'b0, 0);

        // Release of the read bank in the same cycle the next block completes
        pulseInit();
        writeBlockPat(10);
        for (int i = 0; i < 32; i++) cyc(1'b1, i / 4, i % 4, $urandom, $urandom, 1'b1, i);
        checkEq("t4 outEnable held", 32'(obsEn[0]), 32'h1);
        checkEq("t4 idle", 32'(obsIdle[0]), 32'h1);
        readBlock();
        cyc(1'b0, 0, 0, '0, '0, 1'b0, 0);

        // Async reset mid-write, then DataInit mid-read
        for (int i = 0; i <= 12; i++) cyc(1'b1, i / 4, i % 4, $urandom, $urandom, 1'b0, 0);
        rst = 1'b0;
        cyc(1'b0, 0, 0, '0, '0, 1'b0, 0);
        rst = 1'b1;
        writeBlockPat(20);
        for (int a = 0; a < 10; a++) cyc(1'b0, 0, 0, '0, '0, 1'b1, a);
        pulseInit();
        checkEq("t5 init outA", 32'(obsA[0]), 32'h0);
        checkEq("t5 init outEnable", 32'(obsEn), 32'h0);
        writeBlockPat(30);
        readBlock();

        // Random traffic with independent writer and reader
        pulseInit();
        beat = 0;
        ra = 0;
        for (int n = 0; n < 1500; n++) begin
            bit e, r;
            e = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 5);
            x = $urandom;
            y = $urandom;
            x = 32'($signed(x) >>> $urandom_range(0, 12));
            y = 32'($signed(y) >>> $urandom_range(0, 12));
            cyc(e, beat / 4, beat % 4, x, y, r, ra);
            if (e) beat = (beat + 1) % 32;
            if (r) ra = (ra + 1) % 32;
        end
        cyc(1'b0, 0, 0, '0, '0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
